// File: rtl/ripple_count_ctrl_pkg.sv
// Shared types and default constants for the ripple counter sequencer/checker.
package ripple_count_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_PULSE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_e;

  localparam int DEF_WIDTH         = 4;
  localparam int DEF_CLR_CYCLES    = 2;
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int SETTLE_CNT_W      = $clog2(DEF_SETTLE_CYCLES + 2);

endpackage

// File: rtl/ripple_count_ctrl_sync_2ff.sv
// Single-bit two-flop synchroniser with asynchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ripple_count_ctrl.sv
// Sequencer that clears, pulses and self-checks an external ripple up-counter
// against an internal shadow count once the ripple chain has settled.
module ripple_count_ctrl
  import ripple_count_ctrl_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int CLR_CYCLES    = DEF_CLR_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_pulse,
  output logic             cnt_clr,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] count
);

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 2);
  localparam int CLR_W    = $clog2(CLR_CYCLES + 1);
  localparam int TMR_W    = (SETTLE_W > CLR_W) ? SETTLE_W : CLR_W;

  localparam logic [TMR_W-1:0] CLR_LAST    = TMR_W'(CLR_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES + 1);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   target_q, target_d;
  logic               err_q, err_d;
  logic               cnt_pulse_q, cnt_pulse_d;
  logic               cnt_clr_q, cnt_clr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   cnt_sync;
  logic               abort_run;

  // Each bit is synchronised independently; the word is only compared after
  // the settle window, when the counter is no longer moving.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sync
      sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (cnt_q[gi]),
        .q_o   (cnt_sync[gi])
      );
    end
  endgenerate

  assign abort_run = abort && (state_q != ST_IDLE);

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q + 1'b1;
    count_d  = count_q;
    target_d = target_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        tmr_d = '0;
        if (start) begin
          target_d = target;
          err_d    = 1'b0;
          count_d  = '0;
          state_d  = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (tmr_q == CLR_LAST) begin
          tmr_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_PULSE: begin
        tmr_d   = '0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (tmr_q == SETTLE_LAST) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (cnt_sync != count_q) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (count_q == target_q) begin
          state_d = ST_DONE;
        end else begin
          count_d = count_q + 1'b1;
          state_d = ST_PULSE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides everything, including a pending mismatch or done.
    if (abort_run) begin
      state_d  = ST_IDLE;
      tmr_d    = '0;
      count_d  = '0;
      err_d    = err_q;
    end

    cnt_pulse_d = (state_d == ST_PULSE);
    cnt_clr_d   = (state_d == ST_CLEAR) || abort_run;
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      count_q     <= '0;
      target_q    <= '0;
      err_q       <= 1'b0;
      cnt_pulse_q <= 1'b0;
      cnt_clr_q   <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      count_q     <= count_d;
      target_q    <= target_d;
      err_q       <= err_d;
      cnt_pulse_q <= cnt_pulse_d;
      cnt_clr_q   <= cnt_clr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cnt_pulse = cnt_pulse_q;
  assign cnt_clr   = cnt_clr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign count     = count_q;

endmodule
